swc_rtu_rsp_source: RTL and testbench



---
 rtl/swc_rtu_rsp_pkg.sv | 24 ++
 rtl/swc_rtu_rsp_fifo.sv | 68 ++++++
 rtl/swc_rtu_rsp_source.sv | 110 +++++++++++
 tb/tb_swc_rtu_rsp_source.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/swc_rtu_rsp_pkg.sv
// Shared types and helpers for the RTU response source.
package swc_rtu_rsp_pkg;

  localparam int unsigned c_swc_num_ports  = 7;
  localparam int unsigned c_swc_prio_width = 3;

  // One routing decision as buffered per port.
  typedef struct packed {
    logic [c_swc_num_ports-1:0]  mask;
    logic                        drop;
    logic [c_swc_prio_width-1:0] prio;
  } t_rtu_rsp;

  // Bits needed to index n entries (at least 1).
  function automatic int unsigned f_log2_size(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int i = 31; i >= 1; i--) begin
      if ((64'd1 << i) >= 64'(n)) r = int'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/swc_rtu_rsp_fifo.sv
// Per-port response FIFO: power-of-two depth, registered full flag, head read
// straight from storage at the read pointer.
module swc_rtu_rsp_fifo
  import swc_rtu_rsp_pkg::*;
#(
  parameter type         T       = t_rtu_rsp,
  parameter int unsigned g_depth = 4,
  localparam int unsigned PtrW   = f_log2_size(g_depth),
  localparam int unsigned CntW   = PtrW + 1
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            push_i,
  input  T                data_i,
  input  logic            pop_i,
  output logic            full_o,
  output logic            empty_o,
  output T                head_o,
  output logic [CntW-1:0] count_o
);

  localparam logic [CntW-1:0] Depth = CntW'(g_depth);

  T                mem_q [g_depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            full_q, full_d;
  logic            do_push, do_pop;

  // Pop only when non-empty; a push to a full FIFO is taken only if a pop frees a slot.
  always_comb begin
    do_pop   = pop_i & (cnt_q != '0);
    do_push  = push_i & (~full_q | do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push && !do_pop) cnt_d = cnt_q + CntW'(1);
    else if (do_pop && !do_push) cnt_d = cnt_q - CntW'(1);
    full_d   = (cnt_d == Depth);
  end

  // Pointer, occupancy and full-flag state.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
    end
  end

  // Entry storage; contents are only visible while the count says they are live.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign full_o  = full_q;
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/swc_rtu_rsp_source.sv
// RTU response producer: demuxes match-engine results into per-port FIFOs and
// presents each port's head decision to the swcore.
module swc_rtu_rsp_source
  import swc_rtu_rsp_pkg::*;
#(
  parameter int unsigned g_num_ports  = c_swc_num_ports,
  parameter int unsigned g_prio_width = c_swc_prio_width,
  parameter int unsigned g_fifo_depth = 4,
  localparam int unsigned PortW       = f_log2_size(g_num_ports)
) (
  input  logic                                clk_i,
  input  logic                                rst_n_i,
  input  logic                                req_valid_i,
  input  logic [PortW-1:0]                    req_port_i,
  input  logic [g_num_ports-1:0]              req_mask_i,
  input  logic                                req_drop_i,
  input  logic [g_prio_width-1:0]             req_prio_i,
  output logic [g_num_ports-1:0]              req_full_o,
  output logic [g_num_ports-1:0]              req_ovf_o,
  output logic                                req_err_o,
  output logic [g_num_ports-1:0]              rtu_rsp_valid_o,
  input  logic [g_num_ports-1:0]              rtu_rsp_ack_i,
  output logic [g_num_ports*g_num_ports-1:0]  rtu_dst_port_mask_o,
  output logic [g_num_ports-1:0]              rtu_drop_o,
  output logic [g_num_ports*g_prio_width-1:0] rtu_prio_o
);

  localparam int unsigned     CntW      = f_log2_size(g_fifo_depth) + 1;
  localparam logic [CntW-1:0] FullCnt   = CntW'(g_fifo_depth);
  localparam logic [PortW:0]  NumPortsW = (PortW + 1)'(g_num_ports);

  typedef struct packed {
    logic [g_num_ports-1:0]  mask;
    logic                    drop;
    logic [g_prio_width-1:0] prio;
  } rsp_t;

  rsp_t                   wr_data;
  rsp_t                   head [g_num_ports];
  logic [CntW-1:0]        count [g_num_ports];
  logic [g_num_ports-1:0] push, pop, empty, full;
  logic [g_num_ports-1:0] ovf_q, ovf_d;
  logic                   err_q, err_d;
  logic                   port_ok;

  // Write demux, drop rule, and overflow/error detection for next-cycle pulses.
  always_comb begin
    port_ok      = {1'b0, req_port_i} < NumPortsW;
    wr_data.mask = req_drop_i ? '0 : req_mask_i;
    wr_data.drop = req_drop_i;
    wr_data.prio = req_prio_i;
    push         = '0;
    pop          = '0;
    ovf_d        = '0;
    for (int i = 0; i < int'(g_num_ports); i++) begin
      push[i]  = req_valid_i & port_ok & (req_port_i == PortW'(i));
      pop[i]   = rtu_rsp_ack_i[i] & ~empty[i];
      ovf_d[i] = push[i] & (count[i] == FullCnt) & ~pop[i];
    end
    err_d = req_valid_i & ~port_ok;
  end

  // Single-cycle status pulses.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ovf_q <= '0;
      err_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      err_q <= err_d;
    end
  end

  for (genvar g = 0; g < int'(g_num_ports); g++) begin : g_port
    swc_rtu_rsp_fifo #(
      .T       (rsp_t),
      .g_depth (g_fifo_depth)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .push_i  (push[g]),
      .data_i  (wr_data),
      .pop_i   (rtu_rsp_ack_i[g]),
      .full_o  (full[g]),
      .empty_o (empty[g]),
      .head_o  (head[g]),
      .count_o (count[g])
    );
  end

  // Output packing; head fields read as zero while a port has nothing pending.
  always_comb begin
    rtu_rsp_valid_o     = ~empty;
    rtu_dst_port_mask_o = '0;
    rtu_drop_o          = '0;
    rtu_prio_o          = '0;
    for (int i = 0; i < int'(g_num_ports); i++) begin
      if (!empty[i]) begin
        rtu_dst_port_mask_o[i*g_num_ports +: g_num_ports] = head[i].mask;
        rtu_drop_o[i]                                     = head[i].drop;
        rtu_prio_o[i*g_prio_width +: g_prio_width]        = head[i].prio;
      end
    end
  end

  assign req_full_o = full;
  assign req_ovf_o  = ovf_q;
  assign req_err_o  = err_q;

endmodule

// File: tb/tb_swc_rtu_rsp_source.sv
// Bench for swc_rtu_rsp_source: per-port scoreboard queues checked every cycle,
// a vector table for single decisions, and directed multi-cycle sequences.
module tb_swc_rtu_rsp_source;

  localparam int N = 7;
  localparam int P = 3;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic [2:0]    req_port;
  logic [N-1:0]  req_mask;
  logic          req_drop;
  logic [P-1:0]  req_prio;
  logic [N-1:0]  req_full, req_ovf, rsp_valid, ack, rsp_drop;
  logic          req_err;
  logic [N*N-1:0] rsp_mask;
  logic [N*P-1:0] rsp_prio;

  always #5 clk = ~clk;

  swc_rtu_rsp_source dut (
    .clk_i               (clk),
    .rst_n_i             (rst_n),
    .req_valid_i         (req_valid),
    .req_port_i          (req_port),
    .req_mask_i          (req_mask),
    .req_drop_i          (req_drop),
    .req_prio_i          (req_prio),
    .req_full_o          (req_full),
    .req_ovf_o           (req_ovf),
    .req_err_o           (req_err),
    .rtu_rsp_valid_o     (rsp_valid),
    .rtu_rsp_ack_i       (ack),
    .rtu_dst_port_mask_o (rsp_mask),
    .rtu_drop_o          (rsp_drop),
    .rtu_prio_o          (rsp_prio)
  );

  typedef struct packed {
    logic [N-1:0] mask;
    logic         drop;
    logic [P-1:0] prio;
  } ent_t;

  typedef struct {
    logic [2:0]   port;
    logic [N-1:0] mask;
    logic         drop;
    logic [P-1:0] prio;
    logic [N-1:0] e_valid;
    logic [N-1:0] e_mask;
    logic         e_drop;
    logic [P-1:0] e_prio;
    logic         e_err;
  } vec_t;

  ent_t         sb [N][$];
  logic [N-1:0] exp_ovf;
  logic         exp_err;
  int           n_chk = 0;
  int           n_err = 0;
  vec_t         vecs [5];

  function automatic logic [N-1:0] mask_of(input int p);
    return rsp_mask[p*N +: N];
  endfunction

  function automatic logic [P-1:0] prio_of(input int p);
    return rsp_prio[p*P +: P];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_in();
    req_valid = 1'b0;
    req_port  = '0;
    req_mask  = '0;
    req_drop  = 1'b0;
    req_prio  = '0;
    ack       = '0;
  endtask

  // Compare every port against its scoreboard queue.
  task automatic model_check();
    for (int p = 0; p < N; p++) begin
      chk($sformatf("valid[%0d]", p), 32'(rsp_valid[p]), 32'(sb[p].size() != 0));
      chk($sformatf("full[%0d]", p), 32'(req_full[p]), 32'(sb[p].size() == D));
      chk($sformatf("ovf[%0d]", p), 32'(req_ovf[p]), 32'(exp_ovf[p]));
      if (sb[p].size() != 0) begin
        chk($sformatf("mask[%0d]", p), 32'(mask_of(p)), 32'(sb[p][0].mask));
        chk($sformatf("drop[%0d]", p), 32'(rsp_drop[p]), 32'(sb[p][0].drop));
        chk($sformatf("prio[%0d]", p), 32'(prio_of(p)), 32'(sb[p][0].prio));
      end
    end
    chk("err", 32'(req_err), 32'(exp_err));
  endtask

  // Predict the effect of the currently driven inputs at the coming edge.
  task automatic model_update();
    logic [N-1:0] popped;
    logic         was_full;
    ent_t         e;
    exp_ovf = '0;
    exp_err = 1'b0;
    for (int p = 0; p < N; p++) popped[p] = ack[p] && (sb[p].size() != 0);
    if (req_valid) begin
      if (req_port >= 3'(N)) begin
        exp_err = 1'b1;
      end else begin
        was_full = (sb[req_port].size() == D);
        e.mask = req_drop ? '0 : req_mask;
        e.drop = req_drop;
        e.prio = req_prio;
        if (!was_full || popped[req_port]) sb[req_port].push_back(e);
        else exp_ovf[req_port] = 1'b1;
      end
    end
    for (int p = 0; p < N; p++) begin
      if (popped[p]) void'(sb[p].pop_front());
    end
  endtask

  // One clock: check at the falling edge, update model, return just after the rising edge.
  task automatic tick();
    @(negedge clk);
    model_check();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int port, input logic [N-1:0] m, input logic d, input logic [P-1:0] pr);
    req_valid = 1'b1;
    req_port  = 3'(port);
    req_mask  = m;
    req_drop  = d;
    req_prio  = pr;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    clear_in();
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    vecs[0] = '{3'd2, 7'h15, 1'b0, 3'd5, 7'b0000100, 7'h15, 1'b0, 3'd5, 1'b0};
    vecs[1] = '{3'd5, 7'h7F, 1'b1, 3'd3, 7'b0100000, 7'h00, 1'b1, 3'd3, 1'b0};
    vecs[2] = '{3'd7, 7'h7F, 1'b0, 3'd2, 7'b0000000, 7'h00, 1'b0, 3'd0, 1'b1};
    vecs[3] = '{3'd6, 7'h40, 1'b0, 3'd7, 7'b1000000, 7'h40, 1'b0, 3'd7, 1'b0};
    vecs[4] = '{3'd0, 7'h01, 1'b0, 3'd0, 7'b0000001, 7'h01, 1'b0, 3'd0, 1'b0};

    exp_ovf = '0;
    exp_err = 1'b0;
    clear_in();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_full", 32'(req_full), 0);
    chk("rst_ovf", 32'(req_ovf), 0);
    chk("rst_err", 32'(req_err), 0);
    chk("rst_mask", 32'(rsp_mask), 0);
    chk("rst_drop", 32'(rsp_drop), 0);
    chk("rst_prio", 32'(rsp_prio), 0);
    idle(2);

    // Vector table: one decision into an empty port, then drain it
    for (int k = 0; k < 5; k++) begin
      push(vecs[k].port, vecs[k].mask, vecs[k].drop, vecs[k].prio);
      chk($sformatf("tbl%0d_valid", k), 32'(rsp_valid), 32'(vecs[k].e_valid));
      chk($sformatf("tbl%0d_err", k), 32'(req_err), 32'(vecs[k].e_err));
      if (vecs[k].e_valid != '0) begin
        chk($sformatf("tbl%0d_mask", k), 32'(mask_of(vecs[k].port)), 32'(vecs[k].e_mask));
        chk($sformatf("tbl%0d_drop", k), 32'(rsp_drop[vecs[k].port]), 32'(vecs[k].e_drop));
        chk($sformatf("tbl%0d_prio", k), 32'(prio_of(vecs[k].port)), 32'(vecs[k].e_prio));
        ack[vecs[k].port] = 1'b1;
        tick();
        ack = '0;
      end
      idle(1);
    end

    // Head held stable for 10 cycles without ack, then one ack empties it
    push(2, 7'h15, 1'b0, 3'd5);
    for (int i = 0; i < 10; i++) begin
      chk("hold_mask", 32'(mask_of(2)), 32'h15);
      chk("hold_valid", 32'(rsp_valid[2]), 1);
      tick();
    end
    ack[2] = 1'b1;
    tick();
    ack = '0;
    chk("hold_drain", 32'(rsp_valid[2]), 0);

    // Fill port 0, overflow once, then drain back-to-back in order
    for (int i = 1; i <= 4; i++) push(0, 7'(i), 1'b0, 3'(i));
    chk("p0_full", 32'(req_full[0]), 1);
    push(0, 7'h05, 1'b0, 3'd5);
    chk("p0_ovf_pulse", 32'(req_ovf[0]), 1);
    chk("p0_full_after_ovf", 32'(req_full[0]), 1);
    tick();
    chk("p0_ovf_single", 32'(req_ovf[0]), 0);
    ack[0] = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("p0_order_valid", 32'(rsp_valid[0]), 1);
      chk("p0_order_mask", 32'(mask_of(0)), i);
      tick();
    end
    ack = '0;
    chk("p0_empty", 32'(rsp_valid[0]), 0);
    chk("p0_not_full", 32'(req_full[0]), 0);

    // Full port 3 with simultaneous push and ack: accepted, no overflow
    for (int i = 1; i <= 4; i++) push(3, 7'(8'h10 + i), 1'b0, 3'(i));
    ack[3] = 1'b1;
    push(3, 7'h7F, 1'b0, 3'd6);
    ack = '0;
    chk("p3_no_ovf", 32'(req_ovf[3]), 0);
    chk("p3_still_full", 32'(req_full[3]), 1);
    ack[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) chk("p3_fourth", 32'(mask_of(3)), 32'h7F);
      tick();
    end
    ack = '0;
    idle(1);

    // Random traffic across all ports, including invalid port 7 and overflow
    for (int i = 0; i < 150; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_port  = 3'($urandom_range(0, 7));
      req_mask  = 7'($urandom);
      req_drop  = ($urandom_range(0, 3) == 0);
      req_prio  = 3'($urandom);
      ack       = 7'($urandom) & 7'($urandom);
      tick();
    end
    idle(1);
    ack = '1;
    for (int i = 0; i < 6; i++) tick();
    idle(1);

    // Asynchronous reset with entries queued
    for (int i = 1; i <= 3; i++) push(1, 7'(i), 1'b0, 3'(i));
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(rsp_valid), 0);
    chk("async_mask", 32'(rsp_mask), 0);
    chk("async_prio", 32'(rsp_prio), 0);
    for (int p = 0; p < N; p++) sb[p].delete();
    exp_ovf = '0;
    exp_err = 1'b0;
    idle(2);
    #3 rst_n = 1'b1;
    idle(3);
    chk("post_rst_valid", 32'(rsp_valid), 0);
    chk("post_rst_full", 32'(req_full), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
